snake_dir_queue: RTL and testbench

//  Next-generation direction controller for the snake game. Synchronises and debounces the four

---
 rtl/snake_dir_queue.sv | 110 +++++++++++
 tb/tb_snake_dir_queue.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/snake_dir_queue.sv
// rtl/snake_dir_queue.sv - debounced four-button turn controller with a small turn FIFO
module snake_dir_queue #(
  parameter int         DEBOUNCE_CYCLES = 1000000,
  parameter int         QUEUE_DEPTH     = 2,
  parameter logic [1:0] INIT_DIR        = 2'b00
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             btn1,
  input  logic                             btn2,
  input  logic                             btn3,
  input  logic                             btn4,
  input  logic                             move_tick,
  output logic [1:0]                       direction,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0] queue_count,
  output logic                             turn_applied,
  output logic                             press_dropped
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int QW = $clog2(QUEUE_DEPTH + 1);
  localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] LAST_IDX = PW'(QUEUE_DEPTH - 1);
  localparam logic [QW-1:0] FULL_CNT = QW'(QUEUE_DEPTH);

  logic [3:0]    raw, sync1, sync2, level, press;
  logic [CW-1:0] cnt [4];

  // Bit index equals the direction code: btn1=UP(00) ... btn4=RIGHT(11).
  assign raw = {btn4, btn3, btn2, btn1};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      level <= '0;
      for (int b = 0; b < 4; b++) cnt[b] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int b = 0; b < 4; b++) begin
        if (sync2[b] == level[b]) begin
          cnt[b] <= '0;
        end else if (cnt[b] == DB_LAST) begin
          cnt[b]   <= '0;
          level[b] <= sync2[b];
        end else begin
          cnt[b] <= cnt[b] + 1'b1;
        end
      end
    end
  end

  // A press is the cycle in which the debounced level is about to rise.
  always_comb begin
    for (int b = 0; b < 4; b++)
      press[b] = sync2[b] & ~level[b] & (cnt[b] == DB_LAST);
  end

  logic [1:0]    mem [QUEUE_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, last_ptr;
  logic [1:0]    cand, ref_dir;
  logic          has_cand, accept, pop, full, push, drop;

  always_comb begin
    has_cand = 1'b1;
    cand     = 2'b00;
    if (press[0])      cand = 2'b00;
    else if (press[1]) cand = 2'b01;
    else if (press[2]) cand = 2'b10;
    else if (press[3]) cand = 2'b11;
    else               has_cand = 1'b0;
  end

  assign last_ptr = (wr_ptr == '0) ? LAST_IDX : wr_ptr - 1'b1;
  assign ref_dir  = (queue_count != '0) ? mem[last_ptr] : direction;
  assign accept   = has_cand && (cand != ref_dir) &&
                    !((cand[1] == ref_dir[1]) && (cand[0] != ref_dir[0]));
  assign pop      = move_tick && (queue_count != '0);
  assign full     = (queue_count == FULL_CNT);
  assign push     = accept && (!full || pop);
  assign drop     = accept && full && !pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) mem[i] <= 2'b00;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      queue_count   <= '0;
      direction     <= INIT_DIR;
      turn_applied  <= 1'b0;
      press_dropped <= 1'b0;
    end else begin
      turn_applied  <= pop;
      press_dropped <= drop;
      if (push) begin
        mem[wr_ptr] <= cand;
        wr_ptr      <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        direction <= mem[rd_ptr];
        rd_ptr    <= (rd_ptr == LAST_IDX) ? '0 : rd_ptr + 1'b1;
      end
      if (push && !pop)      queue_count <= queue_count + 1'b1;
      else if (pop && !push) queue_count <= queue_count - 1'b1;
    end
  end

endmodule

// File: tb/tb_snake_dir_queue.sv
// tb/tb_snake_dir_queue.sv - bench for snake_dir_queue against a behavioural turn model
module tb_snake_dir_queue;
  localparam int DB    = 4;
  localparam int DEPTH = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn1 = 1'b0, btn2 = 1'b0, btn3 = 1'b0, btn4 = 1'b0;
  logic       move_tick = 1'b0;
  logic [1:0] direction;
  logic [1:0] queue_count;
  logic       turn_applied, press_dropped;

  int tests = 0;
  int fails = 0;

  snake_dir_queue #(.DEBOUNCE_CYCLES(DB), .QUEUE_DEPTH(DEPTH), .INIT_DIR(2'b00)) dut (
    .clk(clk), .reset(reset), .btn1(btn1), .btn2(btn2), .btn3(btn3), .btn4(btn4),
    .move_tick(move_tick), .direction(direction), .queue_count(queue_count),
    .turn_applied(turn_applied), .press_dropped(press_dropped)
  );

  always #5 clk = ~clk;

  // Model: raw sample history per edge, debounced levels, turn queue, applied direction.
  bit [3:0] hist[$];
  bit [3:0] mlev;
  bit [1:0] mq[$];
  bit [1:0] md;
  bit       mta, mpd;

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < DB + 2; i++) hist.push_back(4'b0000);
    mlev = 4'b0000;
    mq.delete();
    md  = 2'b00;
    mta = 1'b0;
    mpd = 1'b0;
  endtask

  task automatic model_edge();
    bit [3:0] pr;
    bit [3:0] h;
    bit [1:0] c, r;
    bit       have, all, acc, pop, full;
    int       n;
    pr = 4'b0000;
    hist.push_back({btn4, btn3, btn2, btn1});
    while (hist.size() > DB + 3) void'(hist.pop_front());
    n = hist.size();
    // Synchronised value seen at this edge is the raw sample from two edges earlier;
    // the level flips once the last DB such values all disagree with it.
    for (int b = 0; b < 4; b++) begin
      all = 1'b1;
      for (int k = 0; k < DB; k++) begin
        h = hist[n - 3 - k];
        if (h[b] == mlev[b]) all = 1'b0;
      end
      if (all) begin
        mlev[b] = ~mlev[b];
        if (mlev[b]) pr[b] = 1'b1;
      end
    end
    have = 1'b0;
    c    = 2'b00;
    for (int b = 3; b >= 0; b--) if (pr[b]) begin have = 1'b1; c = 2'(b); end
    r    = (mq.size() > 0) ? mq[mq.size() - 1] : md;
    acc  = have && (c != r) && !((c[1] == r[1]) && (c[0] != r[0]));
    pop  = move_tick && (mq.size() > 0);
    full = (mq.size() == DEPTH);
    mta  = pop;
    mpd  = acc && full && !pop;
    if (pop) md = mq.pop_front();
    if (acc && (!full || pop)) mq.push_back(c);
  endtask

  task automatic chk(input string tag, input int got, input int exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("direction", int'(direction), int'(md));
    chk("queue_count", int'(queue_count), mq.size());
    chk("turn_applied", int'(turn_applied), int'(mta));
    chk("press_dropped", int'(press_dropped), int'(mpd));
  endtask

  int drop_seen;

  task automatic step();
    @(posedge clk);
    if (reset) model_reset();
    else model_edge();
    #1;
    check_all();
    if (press_dropped) drop_seen++;
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      0: btn1 = v;
      1: btn2 = v;
      2: btn3 = v;
      default: btn4 = v;
    endcase
  endtask

  task automatic press_btn(input int b, input int hi, input int lo);
    set_btn(b, 1'b1);
    repeat (hi) step();
    set_btn(b, 1'b0);
    repeat (lo) step();
  endtask

  task automatic tick();
    move_tick = 1'b1;
    step();
    move_tick = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    #1;
    check_all();
    step();
    reset = 1'b0;
  endtask

  initial begin
    #2;
    do_reset();
    chk("reset_dir", int'(direction), 0);
    chk("reset_count", int'(queue_count), 0);

    // 1: RIGHT held 20 cycles then applied by one tick
    btn4 = 1'b1;
    repeat (20) step();
    chk("s1_count", int'(queue_count), 1);
    tick();
    chk("s1_dir", int'(direction), 3);
    chk("s1_applied", int'(turn_applied), 1);
    btn4 = 1'b0;
    repeat (10) step();

    // 2: short glitch on UP never produces a press
    press_btn(0, 3, 10);
    chk("s2_count", int'(queue_count), 0);
    chk("s2_dir", int'(direction), 3);

    // 3: reversal and no-op rejection
    do_reset();
    press_btn(1, 8, 8);
    chk("s3_down_rej", int'(queue_count), 0);
    press_btn(2, 8, 8);
    press_btn(3, 8, 8);
    chk("s3_count", int'(queue_count), 1);
    tick();
    chk("s3_dir", int'(direction), 2);

    // 4: overflow drops third press, then two ticks drain in order
    do_reset();
    drop_seen = 0;
    press_btn(2, 8, 8);
    press_btn(1, 8, 8);
    press_btn(3, 8, 8);
    chk("s4_count", int'(queue_count), 2);
    chk("s4_drops", drop_seen, 1);
    tick();
    chk("s4_dir1", int'(direction), 2);
    tick();
    chk("s4_dir2", int'(direction), 1);

    // 5: full FIFO, press lands on a tick cycle -> no drop, order kept
    press_btn(2, 8, 8);
    press_btn(0, 8, 8);
    chk("s5_full", int'(queue_count), 2);
    btn4 = 1'b1;
    repeat (DB + 1) step();
    move_tick = 1'b1;
    step();
    move_tick = 1'b0;
    chk("s5_count", int'(queue_count), 2);
    chk("s5_nodrop", int'(press_dropped), 0);
    chk("s5_dir", int'(direction), 2);
    btn4 = 1'b0;
    repeat (8) step();
    tick();
    chk("s5_dir2", int'(direction), 0);
    tick();
    chk("s5_dir3", int'(direction), 3);

    // 6: reset mid-debounce with one entry queued; held button yields one press after release
    do_reset();
    press_btn(2, 8, 4);
    btn4 = 1'b1;
    repeat (2) step();
    reset = 1'b1;
    model_reset();
    #1;
    chk("s6_dir", int'(direction), 0);
    chk("s6_count", int'(queue_count), 0);
    step();
    reset = 1'b0;
    repeat (20) step();
    chk("s6_one_press", int'(queue_count), 1);
    btn4 = 1'b0;
    repeat (8) step();

    // Random phase
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 11) == 0) btn1 = ~btn1;
      if ($urandom_range(0, 11) == 0) btn2 = ~btn2;
      if ($urandom_range(0, 11) == 0) btn3 = ~btn3;
      if ($urandom_range(0, 11) == 0) btn4 = ~btn4;
      move_tick = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 499) == 0) do_reset();
      else step();
    end
    move_tick = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
